// File: rtl/koa_seq_mult_pkg.sv
// Shared definitions for the sequential Karatsuba significand multiplier:
// FSM state encoding and operand-width derivation helpers.
package koa_seq_mult_pkg;

    localparam int unsigned KOA_SW_DEFAULT = 24;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_LO  = 3'd1,
        MUL_HI  = 3'd2,
        MUL_MID = 3'd3,
        DONE    = 3'd4
    } koa_state_e;

    function automatic int unsigned koa_half_width(input int unsigned sw);
        return sw / 2;
    endfunction

    function automatic bit koa_width_ok(input int unsigned sw);
        return (sw >= 4) && ((sw % 2) == 0);
    endfunction

endpackage

// File: rtl/koa_seq_mult_half_mult.sv
// Combinational unsigned WxW -> 2W multiplier, shared by all three
// Karatsuba partial products.
module koa_half_mult
    import koa_seq_mult_pkg::*;
#(
    parameter int unsigned W = koa_half_width(KOA_SW_DEFAULT) + 1
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);

    assign p_o = (2*W)'(a_i) * (2*W)'(b_i);

endmodule

// File: rtl/koa_seq_mult.sv
// Sequential single-level Karatsuba multiplier: lo, hi and mid partial
// products are formed on one shared multiplier over three cycles.
module koa_seq_mult
    import koa_seq_mult_pkg::*;
#(
    parameter int unsigned SW     = KOA_SW_DEFAULT,
    parameter bit          REG_IN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SW-1:0]   Data_A_i,
    input  logic [SW-1:0]   Data_B_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*SW-1:0] sgf_result_o
);

    localparam int unsigned H  = koa_half_width(SW);
    localparam int unsigned PW = 2*H + 2;
    localparam int unsigned RW = 2*SW + 2;

    if (!koa_width_ok(SW)) begin : g_bad_sw
        $error("koa_seq_mult: SW must be even and >= 4");
    end

    koa_state_e state_q, state_d;
    logic       accept;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state_q == DONE);

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = MUL_LO;
                MUL_LO:  state_d = MUL_HI;
                MUL_HI:  state_d = MUL_MID;
                MUL_MID: state_d = DONE;
                DONE: begin
                    if (accept)         state_d = MUL_LO;
                    else if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    logic [SW-1:0] a_op, b_op;

    if (REG_IN) begin : g_reg_in
        logic [SW-1:0] a_q, b_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                a_q <= '0;
                b_q <= '0;
            end else if (accept) begin
                a_q <= Data_A_i;
                b_q <= Data_B_i;
            end
        end

        assign a_op = a_q;
        assign b_op = b_q;
    end else begin : g_direct_in
        assign a_op = Data_A_i;
        assign b_op = Data_B_i;
    end

    logic [H:0]    mul_a, mul_b;
    logic [PW-1:0] mul_p;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            MUL_LO: begin
                mul_a = {1'b0, a_op[H-1:0]};
                mul_b = {1'b0, b_op[H-1:0]};
            end
            MUL_HI: begin
                mul_a = {1'b0, a_op[SW-1:H]};
                mul_b = {1'b0, b_op[SW-1:H]};
            end
            MUL_MID: begin
                mul_a = {1'b0, a_op[SW-1:H]} + {1'b0, a_op[H-1:0]};
                mul_b = {1'b0, b_op[SW-1:H]} + {1'b0, b_op[H-1:0]};
            end
            default: ;
        endcase
    end

    koa_half_mult #(.W(H + 1)) u_half_mult (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    logic [2*H-1:0] p_lo_q, p_hi_q;
    logic [PW-1:0]  p_mid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_lo_q  <= '0;
            p_hi_q  <= '0;
            p_mid_q <= '0;
        end else if (flush) begin
            p_lo_q  <= '0;
            p_hi_q  <= '0;
            p_mid_q <= '0;
        end else begin
            case (state_q)
                MUL_LO:  p_lo_q  <= mul_p[2*H-1:0];
                MUL_HI:  p_hi_q  <= mul_p[2*H-1:0];
                MUL_MID: p_mid_q <= mul_p;
                default: ;
            endcase
        end
    end

    // The result loads on the same edge that registers P_mid, so the mid
    // product is forwarded straight from the multiplier in that cycle.
    logic [PW-1:0] p_mid_cur;
    logic [RW-1:0] wide_sum;
    logic          result_load;
    logic [2*SW-1:0] result_q;

    assign p_mid_cur   = (state_q == MUL_MID) ? mul_p : p_mid_q;
    assign wide_sum    = (RW'(p_hi_q) << SW)
                       + ((RW'(p_mid_cur) - RW'(p_hi_q) - RW'(p_lo_q)) << H)
                       + RW'(p_lo_q);
    assign result_load = (state_q == MUL_MID) && !flush;

    always_comb begin
        if (result_load) assert (wide_sum[RW-1:2*SW] == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             result_q <= '0;
        else if (result_load) result_q <= wide_sum[2*SW-1:0];
    end

    assign sgf_result_o = result_q;

endmodule

// File: tb/tb_koa_seq_mult.sv
// Directed and random checks of koa_seq_mult at SW=24, with SW=4 and SW=54
// instances running in lockstep on the same control stimulus.
module tb_koa_seq_mult;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [63:0]  a_in = '0;
    logic [63:0]  b_in = '0;

    logic         in_ready, out_valid;
    logic [47:0]  res24;
    logic         in_ready4, out_valid4;
    logic [7:0]   res4;
    logic         in_ready54, out_valid54;
    logic [107:0] res54;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    koa_seq_mult dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .Data_A_i(a_in[23:0]), .Data_B_i(b_in[23:0]), .out_valid(out_valid),
        .out_ready(out_ready), .sgf_result_o(res24)
    );

    koa_seq_mult #(.SW(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .Data_A_i(a_in[3:0]), .Data_B_i(b_in[3:0]), .out_valid(out_valid4),
        .out_ready(out_ready), .sgf_result_o(res4)
    );

    koa_seq_mult #(.SW(54)) dut54 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready54),
        .Data_A_i(a_in[53:0]), .Data_B_i(b_in[53:0]), .out_valid(out_valid54),
        .out_ready(out_ready), .sgf_result_o(res54)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Accept one operand pair from IDLE or DONE; out_valid must appear on the
    // 4th rising edge counting the one that samples the accept.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] exp);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        step(1);
        in_valid = 1'b0;
        a_in     = {$urandom, $urandom};
        b_in     = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            check({tag, "_early_valid"}, out_valid, 0);
            step(1);
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_result"}, res24, exp);
    endtask

    initial begin
        logic [63:0]  a_v, b_v;
        logic [127:0] e4, e24, e54;

        // Reset: asserted between edges, held across two edges.
        #2 rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", res24, 0);
        step(2);
        check("rst_in_ready4", in_ready4, 1);
        check("rst_in_ready54", in_ready54, 1);
        rst = 1'b1;
        step(1);

        run_op("max", 64'hFFFFFF, 64'hFFFFFF, 128'hFFFFFE000001);
        run_op("msb", 64'h800000, 64'h800000, 128'h400000000000);
        run_op("zero_a", 64'h0, 64'h123456, 128'h0);
        step(1);
        check("idle_after_hs", in_ready, 1);

        // Back-to-back with in_valid and out_ready held high.
        a_in = 64'd3; b_in = 64'd5; in_valid = 1'b1;
        step(1);
        a_in = 64'd7; b_in = 64'd11;
        step(3);
        check("b2b1_valid", out_valid, 1);
        check("b2b1_result", res24, 15);
        check("b2b1_in_ready", in_ready, 1);
        step(1);
        check("b2b2_gap", out_valid, 0);
        a_in = 64'hABCDEF; b_in = 64'd1;
        step(3);
        check("b2b2_valid", out_valid, 1);
        check("b2b2_result", res24, 77);
        step(1);
        check("b2b3_gap", out_valid, 0);
        in_valid = 1'b0;
        step(3);
        check("b2b3_valid", out_valid, 1);
        check("b2b3_result", res24, 128'hABCDEF);
        step(1);

        // Consumer stall for 10 cycles in DONE; in_valid wiggles meanwhile.
        a_in = 64'h123; b_in = 64'h456; in_valid = 1'b1;
        step(1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step(3);
        check("stall_valid", out_valid, 1);
        check("stall_result", res24, 128'h4EDC2);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            step(1);
            check("stall_hold_valid", out_valid, 1);
            check("stall_hold_result", res24, 128'h4EDC2);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", in_ready, 1);
        step(1);
        check("stall_idle_valid", out_valid, 0);
        check("stall_idle_ready", in_ready, 1);
        check("retain_result", res24, 128'h4EDC2);

        // Flush while in MUL_HI.
        a_in = 64'd9; b_in = 64'd9; in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("flush_idle", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("flush_no_valid", out_valid, 0);
            step(1);
        end
        check("flush_keep_result", res24, 128'h4EDC2);

        // Flush beats a simultaneous accept.
        a_in = 64'd5; b_in = 64'd5; in_valid = 1'b1; flush = 1'b1;
        step(1);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_prio_idle", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("flush_prio_no_valid", out_valid, 0);
            step(1);
        end
        run_op("after_flush", 64'd2, 64'd3, 128'd6);
        step(1);

        // Asynchronous reset in MUL_MID.
        a_in = 64'hFFFFFF; b_in = 64'd2; in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(2);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_result", res24, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        step(1);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("mid_rst_no_late_valid", out_valid, 0);
        end
        check("mid_rst_result_held", res24, 0);

        // Random operands on all three widths, back-to-back.
        for (int i = 0; i < 10000; i++) begin
            a_v = {$urandom, $urandom};
            b_v = {$urandom, $urandom};
            if (i == 0) begin
                a_v = '1;
                b_v = '1;
            end
            e4  = 128'(a_v[3:0]) * 128'(b_v[3:0]);
            e24 = 128'(a_v[23:0]) * 128'(b_v[23:0]);
            e54 = 128'(a_v[53:0]) * 128'(b_v[53:0]);
            a_in = a_v; b_in = b_v; in_valid = 1'b1;
            step(1);
            in_valid = 1'b0;
            step(3);
            check("rand_valid", {out_valid4, out_valid, out_valid54}, 3'b111);
            check("rand_sw4", res4, e4);
            check("rand_sw24", res24, e24);
            check("rand_sw54", res54, e54);
        end
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/koa_seq_mult.md
KOA_SEQ_MULT -- requirements
Module: koa_seq_mult

Interface
REQ-001 Parameter SW, default 24: operand width in bits; SHALL be even and >= 4, with elaboration failing otherwise.
REQ-002 Parameter H = SW/2 (derived, not overridable): half-operand width.
REQ-003 Parameter REG_IN, default 1: 1 = operands captured into internal registers at accept; 0 = operands SHALL be held stable by the source until out_valid.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 flush  input  1  synchronous abort of the operation in flight.
REQ-007 in_valid  input  1  operands valid.
REQ-008 in_ready  output  1  block can accept operands this cycle.
REQ-009 Data_A_i  input  SW  unsigned significand A.
REQ-010 Data_B_i  input  SW  unsigned significand B.
REQ-011 out_valid  output  1  sgf_result_o holds a completed product.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sgf_result_o  output  2*SW  unsigned product A*B, registered.

Function
REQ-014 Accept occurs on a cycle with in_valid=1 and in_ready=1.
REQ-015 FSM states: IDLE, MUL_LO, MUL_HI, MUL_MID, DONE.
REQ-016 IDLE -> MUL_LO on accept; MUL_LO -> MUL_HI -> MUL_MID -> DONE unconditionally, one cycle each.
REQ-017 MUL_LO SHALL register P_lo = A[H-1:0]*B[H-1:0] (2H bits).
REQ-018 MUL_HI SHALL register P_hi = A[SW-1:H]*B[SW-1:H] (2H bits).
REQ-019 MUL_MID SHALL register P_mid = (A_hi+A_lo)*(B_hi+B_lo), with operand sums H+1 bits and product 2H+2 bits, without truncation.
REQ-020 Entering DONE, the block SHALL load sgf_result_o = (P_hi << SW) + ((P_mid - P_hi - P_lo) << H) + P_lo, computed at 2*SW+2 bits internally and truncated to 2*SW; the truncated bits are provably zero.
REQ-021 Latency: out_valid SHALL rise exactly 4 cycles after the accept edge.
REQ-022 All three partial products SHALL share one (H+1)x(H+1) multiplier instance, time-multiplexed by state.
REQ-023 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise (combinational from state and out_ready).
REQ-024 DONE with out_ready=1 and no new accept -> IDLE; DONE with out_ready=1 and accept -> MUL_LO (back-to-back, one operation per 4 cycles); DONE with out_ready=0 -> DONE.
REQ-025 out_valid=1 exactly in DONE; sgf_result_o SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 sgf_result_o SHALL retain the last product after handshake until the next DONE load.
REQ-027 flush=1 in any state SHALL force IDLE on the next edge, clear out_valid, and discard partial products; sgf_result_o holds its value.
REQ-028 flush has priority over accept in the same cycle; the offered operands are not accepted.
REQ-029 in_valid or out_ready toggling outside its handshake state SHALL have no effect.

Reset
REQ-030 On rst=0, the state SHALL become IDLE immediately, independent of clk.
REQ-031 On rst=0, out_valid, sgf_result_o, P_lo, P_hi, P_mid and operand registers SHALL be cleared to 0.
REQ-032 in_ready SHALL read 1 while rst=0 and after release.
REQ-033 Reset mid-operation SHALL discard the operation with no late out_valid.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding and the SW/H width-derivation constants.
REQ-035 One sub-module, koa_half_mult (combinational, parameter W=H+1, unsigned WxW -> 2W), SHALL implement the shared multiplier.
REQ-036 Result register behaviour SHALL match the codebase RegisterAdd semantics (load-enabled, reset-cleared).

Verification
REQ-037 SW=24: A=0xFFFFFF, B=0xFFFFFF accepted -> out_valid 4 cycles later, sgf_result_o=0xFFFFFE000001.
REQ-038 SW=24: A=0x800000, B=0x800000 -> 0x400000000000; then A=0, B=0x123456 -> 0x000000000000.
REQ-039 Back-to-back with out_ready=1 and in_valid=1 continuously, operand pairs (3,5),(7,11),(0xABCDEF,0x000001) -> results 15, 77, 0xABCDEF on 3 consecutive out_valid pulses 4 cycles apart.
REQ-040 out_ready=0 for 10 cycles in DONE -> out_valid and result stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-041 flush in MUL_HI -> IDLE next cycle, no out_valid; a subsequent op 2*3 -> result 6.
REQ-042 rst=0 asserted between edges during MUL_MID -> outputs 0 immediately, in_ready=1, no out_valid after release; random 10k-vector comparison against A*B for SW in {4, 24, 54}.
